// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem_target memory slice.
package pmem_pkg;

    localparam int RD_LAT_MAX = 4;
    localparam int STAT_W     = 16;
    localparam int DATA_W_MAX = 64;

    // Response entry sized for the widest legal data bus; narrower builds use the low bits.
    typedef struct packed {
        logic [DATA_W_MAX-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/pmem_target_if.sv
// Request/response bus between a requester (master) and pmem_target (slave).
interface pmem_target_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/pmem_rsp_fifo.sv
// Generic response FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module pmem_rsp_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/pmem_target.sv
// Byte-enabled word memory target with RD_LAT-stage reads and a credited response FIFO.
// Define PMEM_TARGET_STATS_EN to add saturating stat_rd / stat_wr / stat_err counters.
module pmem_target
    import pmem_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    pmem_target_if.slave bus
`ifdef PMEM_TARGET_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_err
`endif
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam int          NB      = DATA_W / 8;
    localparam logic [31:0] DEPTH_U = DEPTH;

    logic                live;
    logic [CNT_W-1:0]    used;
    logic                pop;
    logic                accept;
    logic                rd_acc;
    logic                wr_acc;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [RD_LAT-1:0]   pipe_vld;
    rsp_t                pipe_rsp [RD_LAT];
    rsp_t                rd_rsp;
    rsp_t                head;
    logic                fifo_empty;

    assign idx      = bus.req_addr[IDX_W-1:0];
    assign in_range = 32'(bus.req_addr) < DEPTH_U;

    // used counts reads in the pipe plus queued responses; a same-cycle pop frees a credit.
    assign pop           = ~fifo_empty & bus.rsp_ready;
    assign bus.req_ready = live & ~((used == CNT_W'(RSP_DEPTH)) & ~pop);
    assign accept        = bus.req_valid & bus.req_ready;
    assign wr_acc        = accept & bus.req_we;
    assign rd_acc        = accept & ~bus.req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
            used <= '0;
        end else begin
            live <= 1'b1;
            used <= used + CNT_W'(rd_acc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.req_be[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_rsp     = '0;
        rd_rsp.err = ~in_range;
        if (in_range) rd_rsp.rdata[DATA_W-1:0] = mem[idx];
    end

    // Reads sample the array at acceptance, so a write one cycle earlier is already visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_rsp[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            pipe_rsp[0] <= rd_rsp;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_rsp[i] <= pipe_rsp[i-1];
            end
        end
    end

    pmem_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pipe_vld[RD_LAT-1]),
        .din   (pipe_rsp[RD_LAT-1]),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty)
    );

    assign bus.rsp_valid = ~fifo_empty;
    assign bus.rsp_rdata = fifo_empty ? '0 : head.rdata[DATA_W-1:0];
    assign bus.rsp_err   = ~fifo_empty & head.err;

`ifdef PMEM_TARGET_STATS_EN
    logic [STAT_W-1:0] cnt_rd;
    logic [STAT_W-1:0] cnt_wr;
    logic [STAT_W-1:0] cnt_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_err <= '0;
        end else begin
            if (rd_acc && cnt_rd != '1)                cnt_rd  <= cnt_rd + 1'b1;
            if (wr_acc && cnt_wr != '1)                cnt_wr  <= cnt_wr + 1'b1;
            if (rd_acc && !in_range && cnt_err != '1)  cnt_err <= cnt_err + 1'b1;
        end
    end

    assign stat_rd  = cnt_rd;
    assign stat_wr  = cnt_wr;
    assign stat_err = cnt_err;
`endif

endmodule

// File: tb/tb_pmem_target.sv
// Scoreboard bench for pmem_target: directed corner cases plus randomized traffic against a memory model.
module tb_pmem_target;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 10;
    localparam int RD_LAT    = 3;
    localparam int RSP_DEPTH = 2;
    localparam int NB        = DATA_W / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_target_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef PMEM_TARGET_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_err;
`endif

    pmem_target #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PMEM_TARGET_STATS_EN
        ,
        .stat_rd  (stat_rd),
        .stat_wr  (stat_wr),
        .stat_err (stat_err)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        bit                err;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mdl [DEPTH];
    int                checks  = 0;
    int                errors  = 0;
    int                cyc     = 0;
    bit                chk_rdy = 1'b0;
    int                n_rd = 0, n_wr = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one accepted request.
    task automatic model_accept(input bit we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        exp_t e;
        if (we) begin
            n_wr++;
            if (int'(a) < DEPTH)
                for (int b = 0; b < NB; b++)
                    if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            n_rd++;
            e.cyc = cyc;
            if (int'(a) < DEPTH) begin
                e.d = mdl[a]; e.err = 1'b0;
            end else begin
                e.d = '0; e.err = 1'b1; n_err++;
            end
            sb.push_back(e);
        end
    endtask

    task automatic tick(input bit v, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [NB-1:0] be,
                        input bit rr, output bit acc);
        @(negedge clk);
        bus.req_valid = v;  bus.req_we = we; bus.req_addr = a;
        bus.req_wdata = d;  bus.req_be = be; bus.rsp_ready = rr;
        #2;
        if (chk_rdy)
            check("req_ready", bus.req_ready,
                  !(sb.size() == RSP_DEPTH && !(bus.rsp_valid && rr)));
        acc = v && (bus.req_ready === 1'b1);
        if (acc) model_accept(we, a, d, be);
    endtask

    task automatic do_req(input bit we, input int a, input logic [DATA_W-1:0] d,
                          input logic [NB-1:0] be);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 50) begin
            tick(1'b1, we, ADDR_W'(a), d, be, 1'b1, acc);
            n++;
        end
        check("req_accept_timeout", acc, 1);
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        repeat (n) tick(1'b0, 1'b0, '0, '0, '0, rr, acc);
    endtask

    task automatic drain();
        int n = 0;
        bit acc;
        while (sb.size() > 0 && n < 200) begin
            tick(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0; chk_rdy = 1'b0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        n_rd = 0; n_wr = 0; n_err = 0;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err",   bus.rsp_err,   0);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", bus.req_ready, 0);
        @(negedge clk);
        #2 check("ready_after_first_edge", bus.req_ready, 1);
        chk_rdy = 1'b1;
    endtask

    // Monitor: compares every presented response with the scoreboard head, pops on handshake.
    initial forever begin
        @(negedge clk);
        #3;
        if (bus.rsp_valid === 1'b1) begin
            check("rsp_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                check("rsp_rdata", bus.rsp_rdata, sb[0].d);
                check("rsp_err",   bus.rsp_err,   sb[0].err);
                if (bus.rsp_ready === 1'b1) begin
                    check("rsp_latency", (cyc - sb[0].cyc) >= RD_LAT + 1, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int na;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_be = '0;   bus.rsp_ready = 1'b0;

        do_reset(3);

        // Basic write then read, one byte lane.
        do_req(1'b1, 3, 32'h0000_00A5, 4'b0001);
        do_req(1'b0, 3, '0, '0);
        idle(2, 1'b1);

        // Partial-byte merge.
        do_req(1'b1, 5, 32'h1122_3344, 4'b1111);
        do_req(1'b1, 5, 32'hAABB_CCDD, 4'b0101);
        do_req(1'b0, 5, '0, '0);
        drain();

        // Out-of-range read and dropped write.
        do_req(1'b1, 2, 32'h5A5A_5A5A, 4'b1111);
        do_req(1'b0, 12, '0, '0);
        do_req(1'b1, 12, 32'hDEAD_BEEF, 4'b1111);
        do_req(1'b0, 2, '0, '0);
        drain();

        // Back-pressure: credits exhausted, then one pop admits the third read.
        do_req(1'b1, 1, 32'h0000_0101, 4'b1111);
        do_req(1'b1, 2, 32'h0000_0202, 4'b1111);
        do_req(1'b1, 3, 32'h0000_0303, 4'b1111);
        drain();
        na = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, ADDR_W'(na + 1), '0, '0, 1'b0, acc);
            if (acc) na++;
        end
        check("bp_accepted", na, 2);
        check("bp_ready_low", bus.req_ready, 0);
        tick(1'b1, 1'b0, ADDR_W'(na + 1), '0, '0, 1'b1, acc);
        check("bp_pop_admits", acc, 1);
        idle(3, 1'b0);
        drain();

        // Randomized traffic including out-of-range addresses and response stalls.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                 NB'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        // Reset with two reads in flight.
        do_req(1'b0, 1, '0, '0);
        do_req(1'b0, 2, '0, '0);
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
            check("no_rsp_after_reset", bus.rsp_valid, 0);
        end

        // Post-reset traffic: storage cleared, 5 writes, 4 reads, 1 error read.
        do_req(1'b0, 7, '0, '0);
        for (int i = 0; i < 5; i++) do_req(1'b1, i, DATA_W'($urandom), 4'b1111);
        for (int i = 0; i < 3; i++) do_req(1'b0, i, '0, '0);
        do_req(1'b0, 11, '0, '0);
        drain();

`ifdef PMEM_TARGET_STATS_EN
        check("stat_wr",  stat_wr,  n_wr);
        check("stat_rd",  stat_rd,  n_rd);
        check("stat_err", stat_err, n_err);
`endif

        idle(2, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
